// File: rtl/parcv1_mem_responder_if.sv
// Core-side imem/dmem request/response bundle for parcv1_mem_responder.
// The core drives through master; the memory responder serves through slave.
interface parcv1_mem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic [XLEN-1:0] imem_data;
    logic            imem_resp;
    logic            imem_err;

    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_we;
    logic            dmem_req;
    logic [XLEN-1:0] dmem_data;
    logic            dmem_resp;
    logic            dmem_err;

    modport master (
        output imem_addr, imem_req,
        input  imem_data, imem_resp, imem_err,
        output dmem_addr, dmem_wdata, dmem_we, dmem_req,
        input  dmem_data, dmem_resp, dmem_err
    );

    modport slave (
        input  imem_addr, imem_req,
        output imem_data, imem_resp, imem_err,
        input  dmem_addr, dmem_wdata, dmem_we, dmem_req,
        output dmem_data, dmem_resp, dmem_err
    );
endinterface

// File: rtl/parcv1_mem_responder.sv
// Dual-port word-addressed backing store for the five-stage core: read at acceptance,
// stores commit at acceptance, responses emerge from fixed-latency per-port pipelines.
module parcv1_mem_responder #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 16384,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int              IMEM_LAT    = 1,
    parameter int              DMEM_LAT    = 1,
    parameter logic [XLEN-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    parcv1_mem_responder_if.slave bus,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);
    localparam int            AW        = $clog2(DEPTH_WORDS);
    localparam logic [XLEN:0] WIN_BYTES = (XLEN+1)'(DEPTH_WORDS * 4);

    typedef struct packed {
        logic            vld;
        logic            err;
        logic [XLEN-1:0] dat;
    } rsp_t;

    logic [XLEN-1:0] i_off, d_off;
    logic            i_in_win, d_in_win;
    logic [AW-1:0]   i_idx, d_idx;
    logic            i_rd_acc, d_rd_acc, d_st_commit;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fall out of window.
    assign i_off    = bus.imem_addr - BASE_ADDR;
    assign d_off    = bus.dmem_addr - BASE_ADDR;
    assign i_in_win = {1'b0, i_off} < WIN_BYTES;
    assign d_in_win = {1'b0, d_off} < WIN_BYTES;
    assign i_idx    = i_off[AW+1:2];
    assign d_idx    = d_off[AW+1:2];

    assign i_rd_acc    = bus.imem_req & ~rst & i_in_win;
    assign d_rd_acc    = bus.dmem_req & ~rst & ~bus.dmem_we & d_in_win;
    assign d_st_commit = bus.dmem_req & ~rst &  bus.dmem_we & d_in_win;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] i_rd_reg, d_rd_reg;

    // Read-first on both ports: a same-edge fetch of a word being stored sees the old value.
    always_ff @(posedge clk) begin
        i_rd_reg <= mem[i_idx];
    end

    always_ff @(posedge clk) begin
        if (d_st_commit) begin
            mem[d_idx] <= bus.dmem_wdata;
        end
        d_rd_reg <= mem[d_idx];
    end

    logic i_vld0_reg, i_err0_reg;
    logic d_vld0_reg, d_err0_reg, d_st0_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_vld0_reg <= 1'b0;
            i_err0_reg <= 1'b0;
            d_vld0_reg <= 1'b0;
            d_err0_reg <= 1'b0;
            d_st0_reg  <= 1'b0;
        end else begin
            i_vld0_reg <= bus.imem_req;
            i_err0_reg <= bus.imem_req & ~i_in_win;
            d_vld0_reg <= bus.dmem_req;
            d_err0_reg <= bus.dmem_req & ~d_in_win;
            d_st0_reg  <= bus.dmem_req & bus.dmem_we;
        end
    end

    rsp_t i_s0, d_s0, i_out, d_out;

    // Stage 0 data is formed after the registered array read; idle slots carry zero data.
    always_comb begin
        i_s0     = '0;
        i_s0.vld = i_vld0_reg;
        i_s0.err = i_err0_reg;
        if (i_vld0_reg) begin
            i_s0.dat = i_err0_reg ? ERR_DATA : i_rd_reg;
        end
    end

    always_comb begin
        d_s0     = '0;
        d_s0.vld = d_vld0_reg;
        d_s0.err = d_err0_reg;
        if (d_vld0_reg && !d_st0_reg) begin
            d_s0.dat = d_err0_reg ? ERR_DATA : d_rd_reg;
        end
    end

    if (IMEM_LAT == 1) begin : g_i_lat1
        assign i_out = i_s0;
    end else begin : g_i_dly
        rsp_t dly_reg [IMEM_LAT-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < IMEM_LAT-1; k++) dly_reg[k] <= '0;
            end else begin
                dly_reg[0] <= i_s0;
                for (int k = 1; k < IMEM_LAT-1; k++) dly_reg[k] <= dly_reg[k-1];
            end
        end
        assign i_out = dly_reg[IMEM_LAT-2];
    end

    if (DMEM_LAT == 1) begin : g_d_lat1
        assign d_out = d_s0;
    end else begin : g_d_dly
        rsp_t dly_reg [DMEM_LAT-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DMEM_LAT-1; k++) dly_reg[k] <= '0;
            end else begin
                dly_reg[0] <= d_s0;
                for (int k = 1; k < DMEM_LAT-1; k++) dly_reg[k] <= dly_reg[k-1];
            end
        end
        assign d_out = dly_reg[DMEM_LAT-2];
    end

    assign bus.imem_resp = i_out.vld;
    assign bus.imem_err  = i_out.err;
    assign bus.imem_data = i_out.dat;
    assign bus.dmem_resp = d_out.vld;
    assign bus.dmem_err  = d_out.err;
    assign bus.dmem_data = d_out.dat;

    logic [31:0] rd_count_reg, rd_count_next;
    logic [31:0] wr_count_reg, wr_count_next;
    logic [1:0]  rd_inc;
    logic [32:0] rd_sum, wr_sum;

    assign rd_inc = 2'(i_rd_acc) + 2'(d_rd_acc);
    assign rd_sum = {1'b0, rd_count_reg} + 33'(rd_inc);
    assign wr_sum = {1'b0, wr_count_reg} + 33'(d_st_commit);

    always_comb begin
        rd_count_next = rd_sum[32] ? 32'hFFFF_FFFF : rd_sum[31:0];
        wr_count_next = wr_sum[32] ? 32'hFFFF_FFFF : wr_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            rd_count_reg <= rd_count_next;
            wr_count_reg <= wr_count_next;
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
endmodule

// File: tb/tb_parcv1_mem_responder.sv
// Directed bench for parcv1_mem_responder: a table-driven pass on a latency-1 instance, then
// hand sequences for latency 3, concurrent latency 4/2 streams and mid-flight reset.
module tb_parcv1_mem_responder;
    localparam logic [31:0] B   = 32'h8000_0000;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parcv1_mem_responder_if #(.XLEN(32)) ifa ();
    parcv1_mem_responder_if #(.XLEN(32)) ifb ();
    parcv1_mem_responder_if #(.XLEN(32)) ifc ();
    logic [31:0] rd_a, wr_a, rd_b, wr_b, rd_c, wr_c;

    parcv1_mem_responder #(.IMEM_LAT(1), .DMEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .rd_count(rd_a), .wr_count(wr_a));
    parcv1_mem_responder #(.IMEM_LAT(4), .DMEM_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .rd_count(rd_b), .wr_count(wr_b));
    parcv1_mem_responder #(.IMEM_LAT(3), .DMEM_LAT(1)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc), .rd_count(rd_c), .wr_count(wr_c));

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic        e_iresp;
        logic [31:0] e_idata;
        logic        e_ierr;
        logic        e_dresp;
        logic [31:0] e_ddata;
        logic        e_derr;
    } vec_t;

    vec_t vecs [15];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                logic [31:0] wd, logic eir, logic [31:0] eid, logic eie,
                                logic edr, logic [31:0] edd, logic ede);
        vec_t v;
        v.ireq = ir;  v.iaddr = ia;  v.dreq = dr;  v.dwe = dw;  v.daddr = da;  v.wdata = wd;
        v.e_iresp = eir;  v.e_idata = eid;  v.e_ierr = eie;
        v.e_dresp = edr;  v.e_ddata = edd;  v.e_derr = ede;
        return v;
    endfunction

    function automatic logic [63:0] pk(logic r, logic e, logic [31:0] d);
        return {30'd0, r, e, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        ifa.imem_req = 0; ifa.imem_addr = 0; ifa.dmem_req = 0; ifa.dmem_we = 0;
        ifa.dmem_addr = 0; ifa.dmem_wdata = 0;
        ifb.imem_req = 0; ifb.imem_addr = 0; ifb.dmem_req = 0; ifb.dmem_we = 0;
        ifb.dmem_addr = 0; ifb.dmem_wdata = 0;
        ifc.imem_req = 0; ifc.imem_addr = 0; ifc.dmem_req = 0; ifc.dmem_we = 0;
        ifc.dmem_addr = 0; ifc.dmem_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 1, 1, B, 32'h13,                         0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 1, 1, B + 32'hFFFC, 32'hABCD_0123,       0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(1, B, 1, 1, B + 32'h10, 32'hCAFE_F00D,         1, 32'h13, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, B + 32'h10, 0,                     0, 0, 0, 1, 32'hCAFE_F00D, 0);
        vecs[4]  = mk(0, 0, 1, 1, B + 32'h20, 32'h1111_1111,         0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(1, B + 32'h20, 1, 1, B + 32'h20, 32'h2222_2222, 1, 32'h1111_1111, 0, 1, 0, 0);
        vecs[6]  = mk(1, B + 32'h20, 1, 0, 32'h7FFF_FFFC, 0,         1, 32'h2222_2222, 0, 1, BAD, 1);
        vecs[7]  = mk(1, B + 32'h1_0000, 1, 0, B + 32'h1_0000, 0,    1, BAD, 1, 1, BAD, 1);
        vecs[8]  = mk(0, 0, 1, 1, 32'h7FFF_FFFC, 32'h55,             0, 0, 0, 1, 0, 1);
        vecs[9]  = mk(0, 0, 1, 1, B + 32'h1_0000, 32'h66,            0, 0, 0, 1, 0, 1);
        vecs[10] = mk(1, B + 32'hFFFC, 1, 0, B, 0,                   1, 32'hABCD_0123, 0, 1, 32'h13, 0);
        vecs[11] = mk(1, B + 32'h3, 1, 0, B + 32'hFFFE, 0,           1, 32'h13, 0, 1, 32'hABCD_0123, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0,                              0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 1, B, 32'hBAD,                        0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, B, 0,                              0, 0, 0, 1, 32'h13, 0);

        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_imem", pk(ifa.imem_resp, ifa.imem_err, ifa.imem_data), 64'd0);
        chk("reset_a_dmem", pk(ifa.dmem_resp, ifa.dmem_err, ifa.dmem_data), 64'd0);
        chk("reset_b_imem", pk(ifb.imem_resp, ifb.imem_err, ifb.imem_data), 64'd0);
        chk("reset_b_dmem", pk(ifb.dmem_resp, ifb.dmem_err, ifb.dmem_data), 64'd0);
        chk("reset_a_counts", {rd_a, wr_a}, 64'd0);
        chk("reset_c_imem", pk(ifc.imem_resp, ifc.imem_err, ifc.imem_data), 64'd0);
        rst = 1'b0;

        // Latency-1 table: each row's response is visible just after its acceptance edge.
        for (int r = 0; r < 15; r++) begin
            ifa.imem_req   = vecs[r].ireq;
            ifa.imem_addr  = vecs[r].iaddr;
            ifa.dmem_req   = vecs[r].dreq;
            ifa.dmem_we    = vecs[r].dwe;
            ifa.dmem_addr  = vecs[r].daddr;
            ifa.dmem_wdata = vecs[r].wdata;
            tick();
            $display("A row %0d: imem resp=%0b err=%0b data=%h | dmem resp=%0b err=%0b data=%h",
                     r, ifa.imem_resp, ifa.imem_err, ifa.imem_data,
                     ifa.dmem_resp, ifa.dmem_err, ifa.dmem_data);
            chk($sformatf("a_row%0d_imem", r), pk(ifa.imem_resp, ifa.imem_err, ifa.imem_data),
                pk(vecs[r].e_iresp, vecs[r].e_ierr, vecs[r].e_idata));
            chk($sformatf("a_row%0d_dmem", r), pk(ifa.dmem_resp, ifa.dmem_err, ifa.dmem_data),
                pk(vecs[r].e_dresp, vecs[r].e_derr, vecs[r].e_ddata));
        end
        idle_all();
        chk("a_rd_count", 64'(rd_a), 64'd9);
        chk("a_wr_count", 64'(wr_a), 64'd5);

        // Latency-3 fetch: response appears on exactly the third edge after acceptance.
        ifc.dmem_req = 1; ifc.dmem_we = 1; ifc.dmem_addr = B; ifc.dmem_wdata = 32'h13;
        tick();
        ifc.dmem_req = 0; ifc.dmem_we = 0;
        ifc.imem_req = 1; ifc.imem_addr = B;
        tick();
        ifc.imem_req = 0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) tick();
            $display("C cycle %0d: imem resp=%0b data=%h", j, ifc.imem_resp, ifc.imem_data);
            chk($sformatf("c_lat3_cyc%0d", j), pk(ifc.imem_resp, ifc.imem_err, ifc.imem_data),
                (j == 2) ? pk(1, 0, 32'h13) : 64'd0);
        end

        // Concurrent streams on the latency-4/2 instance.
        for (int i = 0; i < 10; i++) begin
            ifb.dmem_req = 1; ifb.dmem_we = 1;
            ifb.dmem_addr = B + 32'(4 * i); ifb.dmem_wdata = 32'hA000_0000 + 32'(i);
            tick();
        end
        ifb.dmem_req = 0; ifb.dmem_we = 0;
        repeat (3) tick();
        for (int k = 0; k < 15; k++) begin
            int ji, jd;
            if (k < 10) begin
                ifb.imem_req = 1; ifb.imem_addr = B + 32'(4 * k);
                ifb.dmem_req = 1; ifb.dmem_addr = B + 32'(4 * (9 - k));
            end else begin
                ifb.imem_req = 0; ifb.dmem_req = 0;
            end
            tick();
            ji = k - 3;
            jd = k - 1;
            $display("B cycle %0d: imem resp=%0b data=%h | dmem resp=%0b data=%h",
                     k, ifb.imem_resp, ifb.imem_data, ifb.dmem_resp, ifb.dmem_data);
            chk($sformatf("b_stream_imem_cyc%0d", k),
                pk(ifb.imem_resp, ifb.imem_err, ifb.imem_data),
                (ji >= 0 && ji < 10) ? pk(1, 0, 32'hA000_0000 + 32'(ji)) : 64'd0);
            chk($sformatf("b_stream_dmem_cyc%0d", k),
                pk(ifb.dmem_resp, ifb.dmem_err, ifb.dmem_data),
                (jd >= 0 && jd < 10) ? pk(1, 0, 32'hA000_0000 + 32'(9 - jd)) : 64'd0);
        end
        chk("b_rd_count", 64'(rd_b), 64'd20);
        chk("b_wr_count", 64'(wr_b), 64'd10);

        // Mid-flight reset: three fetches in flight, plus a store in the reset cycle.
        for (int k = 0; k < 3; k++) begin
            ifb.imem_req = 1; ifb.imem_addr = B + 32'(4 * k);
            tick();
        end
        ifb.imem_req = 0;
        ifb.dmem_req = 1; ifb.dmem_we = 1; ifb.dmem_addr = B; ifb.dmem_wdata = 32'h0000_0BAD;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifb.dmem_req = 0; ifb.dmem_we = 0;
        chk("b_rst_imem", pk(ifb.imem_resp, ifb.imem_err, ifb.imem_data), 64'd0);
        chk("b_rst_dmem", pk(ifb.dmem_resp, ifb.dmem_err, ifb.dmem_data), 64'd0);
        chk("b_rst_counts", {rd_b, wr_b}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("b_post_rst_imem_cyc%0d", k),
                pk(ifb.imem_resp, ifb.imem_err, ifb.imem_data), 64'd0);
        end
        ifb.dmem_req = 1; ifb.dmem_we = 0; ifb.dmem_addr = B;
        tick();
        ifb.dmem_req = 0;
        chk("b_persist_lat_early", pk(ifb.dmem_resp, ifb.dmem_err, ifb.dmem_data), 64'd0);
        tick();
        $display("B persist load: dmem resp=%0b data=%h", ifb.dmem_resp, ifb.dmem_data);
        chk("b_persist_word0", pk(ifb.dmem_resp, ifb.dmem_err, ifb.dmem_data),
            pk(1, 0, 32'hA000_0000));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
